// File: rtl/snake_pkg.sv
// snake_pkg: shared game types, spawner FSM states and LFSR tap masks.
package snake_pkg;
  localparam int MAX_POINTS = 8;
  typedef enum logic [1:0] {MENU, GAME, OVER} game_mode;
  typedef enum logic [1:0] {IDLE, PICK, CHECK, COMMIT} spawn_state_e;
  // Galois right-shift masks for maximal-length polynomials
  localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_24 = 32'h00E1_0000;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;
  function automatic logic [31:0] lfsr_taps(input int w);
    return w == 8 ? TAPS_8 : w == 24 ? TAPS_24 : w == 32 ? TAPS_32 : TAPS_16;
  endfunction
endpackage

// File: rtl/spawn_lfsr.sv
// spawn_lfsr: Galois LFSR with seed load and all-zero lock-up guard.
module spawn_lfsr
  import snake_pkg::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic              clk_75,
  input  logic              rst,
  input  logic              advance,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
  always_ff @(posedge clk_75) begin
    if (rst) state <= LFSR_W'(1);
    else if (load) state <= load_val == '0 ? LFSR_W'(1) : load_val;
    else if (advance) state <= (state >> 1) ^ (state[0] ? TAPS : '0);
  end
endmodule

// File: rtl/point_spawner.sv
// point_spawner: keeps NUM_POINTS food points alive, spawning free tiles via LFSR with bounded retries.
module point_spawner
  import snake_pkg::*;
#(
  parameter int MAP_W = 32,
  parameter int MAP_H = 24,
  parameter int NUM_POINTS = 2,
  parameter int LFSR_W = 16,
  parameter int MAX_TRIES = 8,
  localparam int XW = $clog2(MAP_W),
  localparam int YW = $clog2(MAP_H)
) (
  input  logic                     clk_75,
  input  logic                     rst,
  input  logic                     tick,
  input  game_mode                 mode,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed_in,
  output logic [LFSR_W-1:0]        seed_out,
  input  logic                     mirror,
  input  logic [NUM_POINTS-1:0]    consumed,
  output logic                     query_valid,
  output logic [XW-1:0]            query_x,
  output logic [YW-1:0]            query_y,
  input  logic                     query_occupied,
  output logic [NUM_POINTS*XW-1:0] point_x,
  output logic [NUM_POINTS*YW-1:0] point_y,
  output logic [NUM_POINTS-1:0]    point_valid,
  output logic                     busy
);
  localparam int SW = NUM_POINTS > 1 ? $clog2(NUM_POINTS) : 1;
  localparam int TW = MAX_TRIES > 1 ? $clog2(MAX_TRIES) : 1;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [XW-1:0] X_MOD = XW'(MAP_W - 2);
  localparam logic [YW-1:0] Y_MOD = YW'(MAP_H - 2);
  localparam logic [XW-1:0] X_MAX = XW'(MAP_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MAP_H - 1);
  spawn_state_e state, state_nxt;
  logic [LFSR_W-1:0] lfsr, lfsr_step;
  logic [XW-1:0] raw_x, cand_x;
  logic [YW-1:0] raw_y, cand_y;
  logic [XW-1:0] px [NUM_POINTS];
  logic [YW-1:0] py [NUM_POINTS];
  logic [NUM_POINTS-1:0] valid, pending, hit;
  logic [SW-1:0] slot, first;
  logic [TW-1:0] tries;
  logic in_game, was_game, enter, reject, last_try;
  spawn_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk_75   (clk_75),
    .rst      (rst),
    .advance  (mode == MENU || state == PICK),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr)
  );
  // PICK registers the candidate from the value the LFSR is about to take
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  assign raw_x = XW'(lfsr_step);
  assign raw_y = YW'(lfsr_step >> XW);
  assign in_game = mode == GAME;
  assign enter = in_game & ~was_game;
  assign last_try = tries == TW'(MAX_TRIES - 1);
  assign reject = query_occupied | |hit;
  assign seed_out = lfsr;
  assign query_valid = state == CHECK && in_game;
  assign query_x = cand_x;
  assign query_y = cand_y;
  assign busy = state != IDLE;
  assign point_valid = valid;
  always_comb begin
    first = '0;
    for (int i = NUM_POINTS - 1; i >= 0; i--) if (pending[i]) first = SW'(i);
  end
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_POINTS; i++) hit[i] = valid[i] && px[i] == cand_x && py[i] == cand_y;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = tick && |pending ? PICK : IDLE;
      PICK:    state_nxt = CHECK;
      CHECK:   state_nxt = !reject ? COMMIT : last_try ? IDLE : PICK;
      default: state_nxt = IDLE;
    endcase
    if (!in_game) state_nxt = IDLE;
  end
  always_ff @(posedge clk_75) begin
    if (rst) begin
      state <= IDLE;
      was_game <= 1'b0;
      valid <= '0;
      pending <= '0;
      tries <= '0;
      slot <= '0;
      cand_x <= '0;
      cand_y <= '0;
      for (int i = 0; i < NUM_POINTS; i++) begin
        px[i] <= '0;
        py[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      was_game <= in_game;
      if (state == IDLE) begin
        slot <= first;
        tries <= '0;
      end
      if (state == CHECK && reject && !last_try) tries <= tries + TW'(1);
      if (state == PICK) begin
        cand_x <= raw_x % X_MOD + XW'(1);
        cand_y <= raw_y % Y_MOD + YW'(1);
      end
      for (int i = 0; i < NUM_POINTS; i++) begin
        if (!in_game) begin
          valid[i] <= 1'b0;
          pending[i] <= 1'b0;
        end else if (enter) begin
          valid[i] <= 1'b0;
          pending[i] <= 1'b1;
        end else if (consumed[i] && valid[i]) begin
          valid[i] <= 1'b0;
          pending[i] <= 1'b1;
        end else if (state == COMMIT && slot == SW'(i)) begin
          valid[i] <= 1'b1;
          pending[i] <= 1'b0;
          px[i] <= cand_x;
          py[i] <= cand_y;
        end
      end
    end
  end
  for (genvar g = 0; g < NUM_POINTS; g++) begin : g_out
    assign point_x[g*XW +: XW] = mirror ? X_MAX - px[g] : px[g];
    assign point_y[g*YW +: YW] = mirror ? Y_MAX - py[g] : py[g];
  end
endmodule

// File: tb/tb_point_spawner.sv
// tb_point_spawner: directed checks of spawn latency, retries, seeding, mirroring and mode exits.
module tb_point_spawner;
  import snake_pkg::*;
  logic clk_75 = 1'b0;
  logic rst, tick, seed_load, mirror, query_valid, query_occupied, busy, occ;
  game_mode mode;
  logic [15:0] seed_in, seed_out, m;
  logic [1:0] consumed, point_valid;
  logic [4:0] query_x, query_y, ex0, ey0, ex1, ey1, ax0, ay0, ax1, ay1;
  logic [9:0] point_x, point_y;
  int checks = 0, errors = 0;
  always #5 clk_75 = ~clk_75;
  assign query_occupied = occ;
  point_spawner dut (
    .clk_75(clk_75), .rst(rst), .tick(tick), .mode(mode), .seed_load(seed_load),
    .seed_in(seed_in), .seed_out(seed_out), .mirror(mirror), .consumed(consumed),
    .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
    .query_occupied(query_occupied), .point_x(point_x), .point_y(point_y),
    .point_valid(point_valid), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return s[0] ? (s >> 1) ^ 16'hB400 : s >> 1;
  endfunction
  function automatic logic [4:0] cx(input logic [15:0] s);
    return 5'((s & 16'h001F) % 30 + 1);
  endfunction
  function automatic logic [4:0] cy(input logic [15:0] s);
    return 5'(((s >> 5) & 16'h001F) % 22 + 1);
  endfunction
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_75);
      #1;
    end
  endtask
  task automatic pulse_tick;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask
  task automatic predict(input logic ov, input logic [4:0] ox, input logic [4:0] oy,
                         output logic [4:0] ex, output logic [4:0] ey);
    ex = '0;
    ey = '0;
    for (int k = 0; k < 8; k++) begin
      m = nxt(m);
      ex = cx(m);
      ey = cy(m);
      if (!(ov && ex == ox && ey == oy)) break;
    end
  endtask
  task automatic wait_valid(input string tag, input logic [1:0] want);
    int n = 0;
    while (point_valid !== want && n < 40) begin
      step();
      n++;
    end
    check(tag, point_valid, want);
  endtask
  initial begin
    int q, adj;
    logic prev;
    rst = 1'b1; tick = 1'b0; mode = MENU; seed_load = 1'b0; seed_in = '0;
    mirror = 1'b0; consumed = '0; occ = 1'b0;
    step(2);
    check("rst_valid", point_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_query", query_valid, 0);
    check("rst_seed", seed_out, 16'h0001);
    rst = 1'b0; seed_load = 1'b1; seed_in = 16'h0000;
    step();
    seed_load = 1'b0;
    check("seed_zero", seed_out, 16'h0001);
    mode = GAME; seed_load = 1'b1; seed_in = 16'hACE1;
    step();
    seed_load = 1'b0; m = 16'hACE1;
    check("seed_load", seed_out, 16'hACE1);
    check("enter_valid", point_valid, 0);
    pulse_tick();
    check("pick_busy", busy, 1);
    predict(1'b0, 5'd0, 5'd0, ex0, ey0);
    step();
    check("check_qv", query_valid, 1);
    check("check_qx", query_x, ex0);
    check("check_qy", query_y, ey0);
    step();
    check("lat3_valid", point_valid, 0);
    step();
    check("lat4_valid", point_valid, 2'b01);
    check("slot0_x", point_x[4:0], ex0);
    check("slot0_y", point_y[4:0], ey0);
    check("slot0_range", point_x[4:0] >= 1 && point_x[4:0] <= 30 && point_y[4:0] >= 1 && point_y[4:0] <= 22, 1);
    step(3);
    check("one_per_tick", point_valid, 2'b01);
    check("idle_busy", busy, 0);
    pulse_tick();
    predict(1'b1, ex0, ey0, ex1, ey1);
    wait_valid("spawn1", 2'b11);
    check("slot1_x", point_x[9:5], ex1);
    check("slot1_y", point_y[9:5], ey1);
    check("slot1_range", point_x[9:5] >= 1 && point_x[9:5] <= 30 && point_y[9:5] >= 1 && point_y[9:5] <= 22, 1);
    ax0 = ex0; ay0 = ey0; ax1 = ex1; ay1 = ey1;
    consumed = 2'b01;
    step();
    consumed = '0;
    check("consume", point_valid, 2'b10);
    pulse_tick();
    predict(1'b1, ex1, ey1, ex0, ey0);
    wait_valid("respawn0", 2'b11);
    check("respawn0_x", point_x[4:0], ex0);
    check("respawn0_y", point_y[4:0], ey0);
    check("distinct", {point_x[4:0], point_y[4:0]} != {point_x[9:5], point_y[9:5]}, 1);
    consumed = 2'b01;
    step();
    consumed = '0; occ = 1'b1;
    pulse_tick();
    q = 0; adj = 0; prev = 1'b0;
    repeat (30) begin
      step();
      if (query_valid) q++;
      if (query_valid && prev) adj++;
      prev = query_valid;
    end
    check("occ_queries", q, 8);
    check("occ_spacing", adj, 0);
    check("occ_valid", point_valid, 2'b10);
    check("occ_busy", busy, 0);
    repeat (8) m = nxt(m);
    occ = 1'b0;
    pulse_tick();
    predict(1'b1, ex1, ey1, ex0, ey0);
    wait_valid("after_occ", 2'b11);
    check("after_occ_x", point_x[4:0], ex0);
    check("after_occ_y", point_y[4:0], ey0);
    mode = MENU;
    step();
    mode = GAME; seed_load = 1'b1; seed_in = 16'h0800;
    step();
    seed_load = 1'b0;
    check("reenter_valid", point_valid, 0);
    pulse_tick();
    step(3);
    check("mir_valid", point_valid, 2'b01);
    mirror = 1'b1;
    #1;
    check("mir_x0", point_x[4:0], 30);
    check("mir_y0", point_y[4:0], 22);
    pulse_tick();
    step();
    check("mir_qv", query_valid, 1);
    check("mir_qx", query_x, 1);
    check("mir_qy", query_y, 17);
    step(2);
    check("mir_valid2", point_valid, 2'b11);
    check("mir_x1", point_x[9:5], 30);
    check("mir_y1", point_y[9:5], 6);
    m = 16'h0200;
    mirror = 1'b0; consumed = 2'b01;
    step();
    consumed = '0;
    pulse_tick();
    step();
    check("leave_in_check", query_valid, 1);
    m = nxt(m);
    mode = MENU;
    step();
    check("leave_busy", busy, 0);
    check("leave_qv", query_valid, 0);
    check("leave_valid", point_valid, 0);
    check("menu_lfsr1", seed_out, nxt(m));
    step();
    check("menu_lfsr2", seed_out, nxt(nxt(m)));
    mode = GAME; seed_load = 1'b1; seed_in = 16'hACE1;
    step();
    seed_load = 1'b0;
    pulse_tick();
    wait_valid("repro0", 2'b01);
    check("repro_x0", point_x[4:0], ax0);
    check("repro_y0", point_y[4:0], ay0);
    pulse_tick();
    wait_valid("repro1", 2'b11);
    check("repro_x1", point_x[9:5], ax1);
    check("repro_y1", point_y[9:5], ay1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
